md_sched_ctrl: RTL
==================

// Module: md_sched_ctrl
// PURPOSE
//  Sequences the multi-cycle multiply/divide resource of the 5-stage MIPS pipeline.
//  Accepts mult/multu/div/divu/mthi/mtlo from EX and runs a cycle-accurate busy interval.
//  Owns the HI/LO registers and stalls any HI/LO-using instruction in ID until the result commits.
//  Sits beside the EX-stage ALU; its stall_md output is ORed into the global stall logic.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (legal range >=1)
//  DIV_CYCLES   10  busy cycles for div/divu (legal range >=1)
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   synchronous, active-low reset
//  start_e    in   1   EX-stage instruction is an MD op, valid this cycle
//  md_op_e    in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 ignored
//  rs_e       in   32  forwarded rs operand (dividend / multiplicand / mt source)
//  rt_e       in   32  forwarded rt operand (divisor / multiplier)
//  md_req_d   in   1   ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//  hi         out  32  HI register
//  lo         out  32  LO register
//  busy       out  1   MD operation in progress
//  stall_md   out  1   freeze PC/IF/ID, bubble into EX
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): hi=0, lo=0, busy=0, counter=0, pending results=0; state IDLE.
//    Reset during BUSY aborts the operation; hi/lo do NOT receive the pending result.
//  - FSM: IDLE -> BUSY on accepted mult/multu/div/divu; BUSY -> IDLE when counter reaches 1.
//  - Accept: start_e=1 while busy=0 (IDLE). start_e while busy=1 is ignored (cannot occur legally).
//  - On accept edge: result computed from rs_e/rt_e and held in pend_hi/pend_lo;
//    counter loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from next cycle.
//  - Latency: accept at edge T0 -> busy high for exactly N cycles -> at edge T0+N hi/lo
//    load pend values and busy falls on the same edge; new hi/lo visible cycle after.
//  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. multu: unsigned same.
//  - div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//    divu: unsigned. Divide by zero (rt_e=0): lo=32'hFFFF_FFFF, hi=rs_e, normal busy timing.
//    Signed overflow 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
//  - mthi/mtlo: accepted in IDLE only; hi (resp. lo) <= rs_e at that edge; busy stays 0.
//  - Opcodes 6-7: no state change.
//  - stall_md = md_req_d & (busy | (start_e & md_op_e<=3)); combinational, 0 during reset.
//    mfhi/mflo in ID immediately after an MD op in EX are therefore held until commit.
//  - Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES))+1; never wraps (stops at 0 in IDLE).
// TESTING
//  - mult rs=0xFFFF_FFFD(-3), rt=5 -> busy 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
//  - multu rs=0xFFFF_FFFF, rt=2 -> after 5 cycles hi=0x0000_0001, lo=0xFFFF_FFFE.
//  - div rs=-7, rt=2 -> busy 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; divu rs=7,rt=0 -> lo=0xFFFF_FFFF, hi=7.
//  - md_req_d=1 (mflo) held with mult start -> stall_md=1 for start cycle + 5 busy cycles, 0 on commit.
//  - reset_n=0 on 3rd busy cycle of div -> busy=0, hi=lo=0 next cycle; no later commit.
//  - mthi rs=0x1234_5678 in IDLE -> hi=0x1234_5678 next cycle, busy stays 0, lo unchanged.

Source files
------------

// File: rtl/md_sched_ctrl.sv
// md_sched_ctrl: multi-cycle multiply/divide sequencer for the MIPS pipeline.
// Owns HI/LO, models the busy interval of the MD unit, and stalls ID-stage
// HI/LO users until a pending result has committed.
module md_sched_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_e,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_req_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [31:0]    hi_r, hi_s;
    logic [31:0]    lo_r, lo_s;
    logic [31:0]    pend_hi_r, pend_hi_s;
    logic [31:0]    pend_lo_r, pend_lo_s;
    logic [31:0]    res_hi_s, res_lo_s;
    logic           md_start_s;

    // 32x32 -> 64 product; sign- or zero-extend then keep the low 64 bits.
    function automatic logic [63:0] mul_64(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ext_a * ext_b;
    endfunction

    // Returns {remainder, quotient}. Signed divide works on magnitudes, then
    // restores signs: quotient truncates toward zero, remainder follows the
    // dividend. 0x8000_0000 / -1 falls out as quotient 0x8000_0000, rem 0.
    function automatic logic [63:0] div_64(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        quo   = (mag_b == 32'd0) ? 32'hFFFF_FFFF : (mag_a / mag_b);
        rem   = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
        quo   = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
        rem   = neg_a ? (~rem + 32'd1) : rem;
        return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
    endfunction

    assign md_start_s = start_e & (md_op_e <= OP_DIVU);

    // Arithmetic result of the EX-stage operands, captured on accept.
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (md_op_e)
            OP_MULT:  {res_hi_s, res_lo_s} = mul_64(rs_e, rt_e, 1'b1);
            OP_MULTU: {res_hi_s, res_lo_s} = mul_64(rs_e, rt_e, 1'b0);
            OP_DIV:   {res_hi_s, res_lo_s} = div_64(rs_e, rt_e, 1'b1);
            OP_DIVU:  {res_hi_s, res_lo_s} = div_64(rs_e, rt_e, 1'b0);
            default:  {res_hi_s, res_lo_s} = 64'd0;
        endcase
    end

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (start_e) begin
                    case (md_op_e)
                        OP_MULT, OP_MULTU: begin
                            state_s   = ST_BUSY;
                            cnt_s     = MULT_LOAD;
                            pend_hi_s = res_hi_s;
                            pend_lo_s = res_lo_s;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_s   = ST_BUSY;
                            cnt_s     = DIV_LOAD;
                            pend_hi_s = res_hi_s;
                            pend_lo_s = res_lo_s;
                        end
                        OP_MTHI: hi_s = rs_e;
                        OP_MTLO: lo_s = rs_e;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Commit on the edge where the counter reaches 1; treating 0
                // the same keeps a corrupted counter from locking the unit.
                if (cnt_r <= {{(CW-1){1'b0}}, 1'b1}) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                    hi_s    = pend_hi_r;
                    lo_s    = pend_lo_r;
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = (state_r == ST_BUSY);

    // Stall is combinational so a dependent ID instruction is held in the very
    // cycle its producer sits in EX, before busy has risen.
    assign stall_md = reset_n & md_req_d & (busy | md_start_s);

endmodule
